// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: parser states,
// special scan codes and the printable-key translation table.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_BAT      = 8'hAA;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;

  // Returns {hit, ascii}; upper selects letter case, shifted selects digit symbols.
  function automatic logic [8:0] sc2ascii(input logic [7:0] code, input logic upper,
                                          input logic shifted);
    logic [7:0] l;
    logic [8:0] r;
    l = 8'h00;
    r = 9'h000;
    case (code)
      8'h1C: l = "a";  8'h32: l = "b";  8'h21: l = "c";  8'h23: l = "d";
      8'h24: l = "e";  8'h2B: l = "f";  8'h34: l = "g";  8'h33: l = "h";
      8'h43: l = "i";  8'h3B: l = "j";  8'h42: l = "k";  8'h4B: l = "l";
      8'h3A: l = "m";  8'h31: l = "n";  8'h44: l = "o";  8'h4D: l = "p";
      8'h15: l = "q";  8'h2D: l = "r";  8'h1B: l = "s";  8'h2C: l = "t";
      8'h3C: l = "u";  8'h2A: l = "v";  8'h1D: l = "w";  8'h22: l = "x";
      8'h35: l = "y";  8'h1A: l = "z";
      default: l = 8'h00;
    endcase
    if (l != 8'h00) begin
      r = {1'b1, upper ? (l ^ 8'h20) : l};
    end else begin
      case (code)
        8'h45: r = {1'b1, shifted ? ")" : "0"};
        8'h16: r = {1'b1, shifted ? "!" : "1"};
        8'h1E: r = {1'b1, shifted ? "@" : "2"};
        8'h26: r = {1'b1, shifted ? "#" : "3"};
        8'h25: r = {1'b1, shifted ? "$" : "4"};
        8'h2E: r = {1'b1, shifted ? "%" : "5"};
        8'h36: r = {1'b1, shifted ? "^" : "6"};
        8'h3D: r = {1'b1, shifted ? "&" : "7"};
        8'h3E: r = {1'b1, shifted ? "*" : "8"};
        8'h46: r = {1'b1, shifted ? "(" : "9"};
        8'h29: r = {1'b1, 8'h20};
        8'h5A: r = {1'b1, 8'h0D};
        8'h66: r = {1'b1, 8'h08};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_fifo.sv
// Small synchronous FIFO with a registered head-of-queue output that reads
// 0 when empty and is valid in the same cycle the first entry lands.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CW-1:0]    r_count, w_count_next;
  logic [WIDTH-1:0] r_rdata;
  logic             w_do_push, w_do_pop;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_do_pop     = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push    = i_push && (!o_full || w_do_pop);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
  assign o_rdata      = r_rdata;

  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_ptr_inc;
      // Bypass the array when the incoming entry becomes the new head.
      if (w_count_next == '0)
        r_rdata <= '0;
      else if (w_do_push && (o_empty || (r_count == CW'(1) && w_do_pop)))
        r_rdata <= i_wdata;
      else if (w_do_pop)
        r_rdata <= r_mem[w_rd_ptr_inc];
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code parser: E0/F0 prefix handling, Shift/Caps tracking and
// ASCII translation feeding a character FIFO.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       shift_on,
  output logic       caps_on,
  output logic       overflow
);

  ps2_state_t r_state, w_state_next;
  logic       r_lshift, r_rshift, r_caps, r_caps_armed, r_overflow;
  logic       w_make, w_brk, w_ext, w_is_mod, w_push, w_full, w_empty, w_shift;
  logic [8:0] w_xlat;
  logic [7:0] w_push_data;
  logic       w_prefix;

  assign w_shift  = r_lshift | r_rshift;
  assign w_prefix = (code_in == SC_EXT) || (code_in == SC_BRK);
  assign w_is_mod = (code_in == SC_LSHIFT) || (code_in == SC_RSHIFT) || (code_in == SC_CAPS);
  assign w_xlat   = sc2ascii(code_in, w_shift ^ r_caps, w_shift);

  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    w_ext        = 1'b0;
    if (code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (code_in == SC_EXT)      w_state_next = ST_EXT;
          else if (code_in == SC_BRK) w_state_next = ST_BRK;
          else if (code_in != SC_BAT && code_in != SC_ACK) w_make = 1'b1;
        end
        ST_EXT: begin
          if (code_in == SC_BRK) w_state_next = ST_EXT_BRK;
          else if (code_in != SC_EXT) begin
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (!w_prefix) begin
            w_brk        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          if (!w_prefix) begin
            w_brk        = 1'b1;
            w_ext        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Keypad Enter is the only extended key that produces a character.
  assign w_push      = w_make && (w_ext ? (code_in == SC_KP_ENTER) : (!w_is_mod && w_xlat[8]));
  assign w_push_data = w_ext ? 8'h0D : w_xlat[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_caps       <= 1'b0;
      r_caps_armed <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_make && !w_ext) begin
        if (code_in == SC_LSHIFT) r_lshift <= 1'b1;
        if (code_in == SC_RSHIFT) r_rshift <= 1'b1;
        if (code_in == SC_CAPS && r_caps_armed) begin
          r_caps       <= ~r_caps;
          r_caps_armed <= 1'b0;
        end
      end
      if (w_brk && !w_ext) begin
        if (code_in == SC_LSHIFT) r_lshift <= 1'b0;
        if (code_in == SC_RSHIFT) r_rshift <= 1'b0;
        if (code_in == SC_CAPS)   r_caps_armed <= 1'b1;
      end
      if (w_push && w_full && !out_ready) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (out_ready && out_valid),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign shift_on  = w_shift;
  assign caps_on   = r_caps;
  assign overflow  = r_overflow;

endmodule
